// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V front end: data width, the canonical NOP
// and the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// holds the IF/ID slot handed to decode, with branch/jump redirect support.
module fetch_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        misalign_o
);

  import riscv_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic            valid_q, valid_d;
  logic            misalign_q, misalign_d;
  logic            adv;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      slot_pc_q  <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      slot_pc_q  <= slot_pc_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  // The slot can take a new word when it is empty or decode drains it this cycle.
  assign adv = !valid_q || ready_i;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    slot_pc_d  = slot_pc_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redirect_i) begin
          pc_d = redirect_pc_i;
        end
      end

      FETCH: begin
        // A redirect flushes the slot even when decode is stalled or accepting.
        if (redirect_i) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (redirect_pc_i[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            state_d    = HALT;
          end else begin
            pc_d = redirect_pc_i;
          end
        end else if (adv) begin
          instr_d   = imem_data_i;
          slot_pc_d = pc_q;
          valid_d   = 1'b1;
          pc_d      = pc_q + XLEN'(4);
        end
      end

      HALT: begin
        valid_d = 1'b0;
      end

      default: begin
        state_d = HALT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr_o = pc_q;
  assign valid_o     = valid_q;
  assign instr_o     = instr_q;
  assign pc_o        = slot_pc_q;
  assign pc_plus4_o  = slot_pc_q + XLEN'(4);
  assign misalign_o  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: streaming, stall, redirect,
// misaligned halt, PC wrap and asynchronous reset.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rst2_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ready_i;

  logic [31:0] imem_addr, imem_data;
  logic        valid;
  logic [31:0] instr, pc, pc_plus4;
  logic        misalign;

  logic [31:0] imem_addr2, imem_data2;
  logic        valid2;
  logic [31:0] instr2, pc2, pc_plus42;
  logic        misalign2;

  logic [31:0] rom [64];

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  assign imem_data  = rom[imem_addr[7:2]];
  assign imem_data2 = rom[imem_addr2[7:2]];

  fetch_stage dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ready_i      (ready_i),
    .valid_o      (valid),
    .instr_o      (instr),
    .pc_o         (pc),
    .pc_plus4_o   (pc_plus4),
    .misalign_o   (misalign)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i        (clk_i),
    .rst_ni       (rst2_n),
    .imem_addr_o  (imem_addr2),
    .imem_data_i  (imem_data2),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .ready_i      (ready_i),
    .valid_o      (valid2),
    .instr_o      (instr2),
    .pc_o         (pc2),
    .pc_plus4_o   (pc_plus42),
    .misalign_o   (misalign2)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Advance to just after the next rising edge so outputs are settled.
  task automatic apply_step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hC0DE_0000 + 32'(i);
    rst_ni        = 1'b0;
    rst2_n        = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    ready_i       = 1'b1;

    #12;
    check_output("rst_valid", 32'(valid), 32'd0);
    check_output("rst_instr", instr, 32'h0000_0013);
    check_output("rst_pc", pc, 32'h0);
    check_output("rst_misalign", 32'(misalign), 32'd0);
    check_output("rst_addr", imem_addr, 32'h0);
    rst_ni = 1'b1;

    // Streaming: BOOT edge, then one instruction per edge.
    apply_step();
    check_output("boot_valid", 32'(valid), 32'd0);
    check_output("boot_addr", imem_addr, 32'h0);
    apply_step();
    check_output("s0_valid", 32'(valid), 32'd1);
    check_output("s0_pc", pc, 32'h0);
    check_output("s0_instr", instr, 32'hC0DE_0000);
    check_output("s0_plus4", pc_plus4, 32'h4);
    apply_step();
    check_output("s1_pc", pc, 32'h4);
    check_output("s1_instr", instr, 32'hC0DE_0001);

    // Stall three clocks with B in the slot.
    ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply_step();
      check_output("stall_instr", instr, 32'hC0DE_0001);
      check_output("stall_pc", pc, 32'h4);
      check_output("stall_addr", imem_addr, 32'h8);
      check_output("stall_valid", 32'(valid), 32'd1);
    end
    ready_i = 1'b1;
    apply_step();
    check_output("s2_pc", pc, 32'h8);
    check_output("s2_instr", instr, 32'hC0DE_0002);
    apply_step();
    check_output("s3_pc", pc, 32'hC);
    check_output("s3_instr", instr, 32'hC0DE_0003);

    // Redirect while decode is stalled on a live slot.
    ready_i       = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    apply_step();
    check_output("flush_valid", 32'(valid), 32'd0);
    check_output("flush_instr", instr, 32'h0000_0013);
    check_output("flush_addr", imem_addr, 32'h40);
    redirect_i = 1'b0;
    ready_i    = 1'b1;
    apply_step();
    check_output("tgt_valid", 32'(valid), 32'd1);
    check_output("tgt_instr", instr, 32'hC0DE_0010);
    check_output("tgt_pc", pc, 32'h40);
    check_output("tgt_plus4", pc_plus4, 32'h44);

    // Misaligned redirect halts; later redirects are ignored.
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h42;
    apply_step();
    check_output("mis_flag", 32'(misalign), 32'd1);
    check_output("mis_valid", 32'(valid), 32'd0);
    check_output("mis_addr", imem_addr, 32'h44);
    check_output("mis_instr", instr, 32'h0000_0013);
    redirect_i = 1'b0;
    apply_step();
    check_output("halt_valid", 32'(valid), 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0;
    apply_step();
    check_output("halt_addr", imem_addr, 32'h44);
    check_output("halt_valid2", 32'(valid), 32'd0);
    check_output("halt_flag", 32'(misalign), 32'd1);
    redirect_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("halt_rst_flag", 32'(misalign), 32'd0);
    check_output("halt_rst_addr", imem_addr, 32'h0);
    rst_ni = 1'b1;

    // Reset dropped between edges during a stall.
    apply_step();
    apply_step();
    apply_step();
    check_output("re_pc", pc, 32'h4);
    ready_i = 1'b0;
    apply_step();
    #2;
    rst_ni = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(valid), 32'd0);
    check_output("mid_rst_pc", pc, 32'h0);
    check_output("mid_rst_addr", imem_addr, 32'h0);
    check_output("mid_rst_instr", instr, 32'h0000_0013);
    ready_i = 1'b1;
    rst_ni  = 1'b1;
    apply_step();
    check_output("mid_boot_valid", 32'(valid), 32'd0);
    apply_step();
    check_output("mid_first_valid", 32'(valid), 32'd1);
    check_output("mid_first_pc", pc, 32'h0);

    // PC wrap from the top of the address space.
    check_output("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
    #2;
    rst2_n = 1'b1;
    apply_step();
    check_output("wrap_boot_valid", 32'(valid2), 32'd0);
    apply_step();
    check_output("wrap0_pc", pc2, 32'hFFFF_FFFC);
    check_output("wrap0_plus4", pc_plus42, 32'h0);
    check_output("wrap0_instr", instr2, 32'hC0DE_003F);
    check_output("wrap0_addr", imem_addr2, 32'h0);
    apply_step();
    check_output("wrap1_pc", pc2, 32'h0);
    check_output("wrap1_instr", instr2, 32'hC0DE_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
